// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single-port data RAM
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t            state, state_nxt;
    logic              owner, owner_nxt;
    logic              last_gnt, last_gnt_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              own_req, own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            cnt      <= 3'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        cnt_nxt      = cnt;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        m0_rdata     = '0;
        m1_rdata     = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        // Only the owner's command path is ever visible on the RAM side.
        own_req   = owner ? m1_req   : m0_req;
        own_we    = owner ? m1_we    : m0_we;
        own_addr  = owner ? m1_addr  : m0_addr;
        own_wdata = owner ? m1_wdata : m0_wdata;

        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    owner_nxt = ~last_gnt;
                    state_nxt = ISSUE;
                end else if (m0_req) begin
                    owner_nxt = 1'b0;
                    state_nxt = ISSUE;
                end else if (m1_req) begin
                    owner_nxt = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (own_req) begin
                    mem_en       = 1'b1;
                    mem_we       = own_we;
                    mem_addr     = own_addr;
                    mem_wdata    = own_wdata;
                    m0_gnt       = ~owner;
                    m1_gnt       = owner;
                    last_gnt_nxt = owner;
                    if (own_we) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = 3'd1;
                        state_nxt = WAIT;
                    end
                end else begin
                    // Requester withdrew before being granted: abandon without touching fairness.
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == LAT) begin
                    m0_rvalid = ~owner;
                    m1_rvalid = owner;
                    m0_rdata  = owner ? '0 : mem_rdata;
                    m1_rdata  = owner ? mem_rdata : '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port data RAM inside the SoC.
- Requester 0 is the core instruction-fetch port; requester 1 is the core load/store port, or the program loader during boot.
- Round-robin fairness, req/gnt handshake, fixed read latency to RAM, read data routed back to the owning requester with an rvalid pulse.
- Sits between core_inst/loader and the RAM macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in cycles (legal 1..4).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  requester 0 access request; held until m0_gnt
- m0_we  in  1  requester 0 write enable
- m0_addr  in  ADDR_W  requester 0 address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  requester 0 command accepted (1-cycle pulse)
- m0_rvalid  out  1  requester 0 read data valid (1-cycle pulse)
- m0_rdata  out  DATA_W  requester 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for requester 1
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Reset: clk and rst only. Asynchronous, active-high.
  - State goes to IDLE; owner=0; last_gnt=1, so m0 wins the first tie; cnt=0.
  - All outputs are 0 during reset. Any in-flight read is dropped and no rvalid is issued.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - mem_en=0.
  - If only one req is high, that requester becomes owner.
  - If both are high, owner = the requester that is not last_gnt.
  - Any req high: next state ISSUE. No req: stay in IDLE.
- ISSUE:
  - If owner's req is still high:
    - mem_en=1; mem_we/mem_addr/mem_wdata muxed combinationally from the owner's inputs.
    - owner gnt=1 for this cycle; last_gnt<=owner.
    - Write: next state IDLE.
    - Read: cnt<=1, next state WAIT.
  - If owner's req has dropped (protocol violation): mem_en=0, no gnt, next state IDLE, last_gnt unchanged.
- WAIT:
  - cnt increments each cycle.
  - When cnt==RD_LAT: owner rvalid=1, owner rdata=mem_rdata, next state IDLE.
  - mem_en=0 throughout.
- Timing:
  - Latency: req sampled high in IDLE at cycle t, gnt at t+1, rvalid at t+1+RD_LAT.
  - Write occupancy is 2 cycles; read occupancy is 2+RD_LAT cycles.
- Non-owner: gnt, rvalid and rdata are all 0. rdata is forced to 0 whenever rvalid=0.
- Only one outstanding transaction exists at a time. New reqs arriving during ISSUE or WAIT are ignored until IDLE.
- Fairness: with both reqs continuously high, grants alternate m0, m1, m0, ... No requester waits more than one foreign transaction.
- The non-owner's inputs never reach the mem_* outputs. mem_addr/mem_wdata/mem_we are 0 when mem_en=0.
- Requester obligation: hold req/we/addr/wdata stable from req rise until the gnt cycle inclusive. Deassert req, or present the next request, in the cycle after gnt.

Test Plan:
- Reset, then m0 read addr 0x10 with mem_rdata=0xDEADBEEF at RD_LAT=1 -> m0_gnt at cycle 1, mem_en/mem_addr=0x10 that cycle, m0_rvalid with m0_rdata=0xDEADBEEF at cycle 2, m1_* all 0.
- m1 write addr 0x20 data 0x12345678 -> one mem_en cycle with mem_we=1, mem_addr=0x20, mem_wdata=0x12345678, m1_gnt pulse, no rvalid, FSM back in IDLE next cycle.
- Both requesters reading continuously for 6 transactions from reset -> grant order m0,m1,m0,m1,m0,m1; each rvalid goes only to the granted side with correct data.
- RD_LAT=3, m0 read -> rvalid exactly 3 cycles after the gnt cycle; a m1 req raised during WAIT is granted only after m0_rvalid.
- rst asserted one cycle after m0_gnt for a read -> all outputs 0 immediately, no m0_rvalid after release, next tie is granted to m0.
- m0_req dropped in the ISSUE cycle -> no mem_en, no gnt, return to IDLE; subsequent m1 req is served normally.
